hilo_unit: RTL
==============

// Module: hilo_unit
// PURPOSE
//  HI/LO register owner in EX. It is the write side of the HI/LO pair that MFHI/MFLO read through hilo_rdata_o.
//  Executes MTHI/MTLO, MULT/MULTU (single cycle) and DIV/DIVU (iterative, 32-step restoring divider with pipeline stall).
//  Write ops are aluop codes from cpu.vh; non-HILO ops are ignored.
// PARAMETERS
//  HILO_RST_VAL  64'h0  reset/initial value of {HI,LO}
//  DIV_STEPS     32     divider iterations (= operand width; fixed 32 in this core)
// PORTS
//  clk           in   1   core clock, all state on rising edge
//  resetn        in   1   asynchronous, active-low reset
//  valid_i       in   1   EX holds a live instruction this cycle
//  flush_i       in   1   kill EX instruction (exception/redirect)
//  aluop_i       in   8   cpu.vh op code (MTHI/MTLO/MULT/MULTU/DIV/DIVU acted on)
//  opdata1_i     in   32  rs value (dividend / multiplicand / MTxx source)
//  opdata2_i     in   32  rt value (divisor / multiplier)
//  hilo_rdata_o  out  64  registered {HI,LO}, feeds MFHI/MFLO path
//  stall_o       out  1   hold IF..EX; EX inputs must stay stable while high
//  div_busy_o    out  1   divider FSM not IDLE (debug/perf)
// BEHAVIOUR
//  Reset: {HI,LO}=HILO_RST_VAL, FSM=IDLE, stall_o=0, div_busy_o=0; divider datapath regs cleared.
//  fire = valid_i & ~flush_i. All HI/LO writes take effect at the rising edge; visible on hilo_rdata_o next cycle
//   (the following instruction reaches EX then, so no internal bypass).
//  MTHI: HI<=opdata1_i, LO kept. MTLO: LO<=opdata1_i, HI kept.
//  MULT: {HI,LO}<=signed(op1)*signed(op2), full 64 bits. MULTU: unsigned product. 1 cycle, stall_o=0.
//  FSM IDLE/RUN/DONE:
//   IDLE: fire & DIV/DIVU & op2!=0 -> stall_o=1 (combinational, same cycle), latch |op1|,|op2| (DIV takes abs),
//         latch sign info, count<=0 -> RUN.
//         fire & DIV/DIVU & op2==0 -> no stall; HI<=op1, LO<=32'hFFFF_FFFF (decided divide-by-zero result).
//   RUN : stall_o=1; one restoring step/cycle: {rem,quo} shift left 1, subtract divisor if rem>=divisor, set q bit.
//         count==DIV_STEPS-1 -> DONE.
//   DONE: stall_o=0; LO<=quotient, HI<=remainder, both sign-fixed for DIV:
//         quotient negated iff op1/op2 signs differ; remainder takes sign of op1. DIVU: no fixup. -> IDLE.
//         Pipeline advances this cycle, so the held DIV is not re-issued.
//  Latency: DIV/DIVU issue in cycle 0 -> stall_o high cycles 0..32 -> write at end of cycle 33 (DONE).
//  Flush: flush_i in any state -> next state IDLE, no HI/LO write that cycle; stall_o forced 0 combinationally.
//  Reset mid-division: immediate IDLE, HI/LO to HILO_RST_VAL; no partial result is written.
//  Edge cases: DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0 (wraps, no trap).
//   Inputs changing during RUN are ignored (latched copies used).
//  div_busy_o = (state != IDLE).
// STRUCTURE
//  Opcodes stay in cpu.vh; FSM state encodings (IDLE/RUN/DONE) localparams in cpu.vh divider section.
//  One sub-module: hilo_div (iterative divider core: start, signed, a, b -> done, quo, rem);
//   hilo_unit holds HI/LO regs, op decode, multiply, stall/flush logic.
// TESTING
//  1 MTHI 0x1234_5678 then MTLO 0x9ABC_DEF0 -> hilo_rdata_o = 0x12345678_9ABCDEF0 one cycle after each write.
//  2 MULT 0xFFFF_FFFE * 3 -> {HI,LO}=0xFFFFFFFF_FFFFFFFA; MULTU same -> 0x00000002_FFFFFFFA; no stall.
//  3 DIV -7 / 2 -> stall_o 33 cycles, then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU 100/7 -> LO=14, HI=2.
//  4 DIVU 5 / 0 -> no stall, HI=5, LO=0xFFFF_FFFF next cycle.
//  5 Start DIV 100/3, assert flush_i at cycle 10 -> stall_o=0 that cycle, div_busy_o=0 next, HI/LO unchanged.
//  6 resetn low during RUN -> hilo_rdata_o=HILO_RST_VAL, stall_o=0 immediately;
//    MTHI with valid_i=0 or flush_i=1 -> no write.

Source files
------------

// File: rtl/hilo_unit_pkg.sv
// Shared opcodes, divider FSM states and helpers for the HI/LO unit.
package hilo_unit_pkg;

  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_div.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// with sign fix-up applied to the visible quotient/remainder.
module hilo_div
  import hilo_unit_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        flush,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic        busy,
  output logic        run,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  localparam int unsigned CW = $clog2(DIV_STEPS);

  div_state_t  state;
  logic [CW-1:0] count;
  logic [31:0] divisor;
  logic [31:0] q_reg;
  logic [31:0] r_reg;
  logic        neg_q;
  logic        neg_r;
  logic [32:0] trial;

  // Bit 32 of the trial difference is the borrow: set means rem < divisor.
  assign trial = {r_reg, q_reg[31]} - {1'b0, divisor};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= DIV_IDLE;
      count   <= '0;
      divisor <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (flush) begin
      state <= DIV_IDLE;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (start) begin
            divisor <= mag32(b, is_signed);
            q_reg   <= mag32(a, is_signed);
            r_reg   <= '0;
            neg_q   <= is_signed & (a[31] ^ b[31]);
            neg_r   <= is_signed & a[31];
            count   <= '0;
            state   <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          if (trial[32]) r_reg <= {r_reg[30:0], q_reg[31]};
          else           r_reg <= trial[31:0];
          q_reg <= {q_reg[30:0], ~trial[32]};
          count <= count + 1'b1;
          if (count == CW'(DIV_STEPS - 1)) state <= DIV_DONE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign busy = (state != DIV_IDLE);
  assign run  = (state == DIV_RUN);
  assign done = (state == DIV_DONE);
  assign quo  = neg_q ? (~q_reg + 32'd1) : q_reg;
  assign rem  = neg_r ? (~r_reg + 32'd1) : r_reg;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner in EX: MTHI/MTLO, single-cycle MULT/MULTU and
// iterative DIV/DIVU with pipeline stall.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter logic [63:0] HILO_RST_VAL = 64'h0,
  parameter int unsigned DIV_STEPS    = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] hilo_rdata_o,
  output logic        stall_o,
  output logic        div_busy_o
);

  logic [63:0] hilo;
  logic        fire;
  logic        is_div;
  logic        div_zero;
  logic        start;
  logic        div_done;
  logic        div_run;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign fire     = valid_i & ~flush_i;
  assign is_div   = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign div_zero = (opdata2_i == '0);
  assign start    = fire & is_div & ~div_zero & ~div_busy_o;

  // Stall must drop the instant reset or flush hits, even with a DIV still presented.
  assign stall_o  = resetn & ~flush_i & (start | div_run);

  assign prod_s = $signed({{32{opdata1_i[31]}}, opdata1_i}) *
                  $signed({{32{opdata2_i[31]}}, opdata2_i});
  assign prod_u = {32'b0, opdata1_i} * {32'b0, opdata2_i};

  hilo_div #(
    .DIV_STEPS(DIV_STEPS)
  ) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .flush    (flush_i),
    .is_signed(aluop_i == OP_DIV),
    .a        (opdata1_i),
    .b        (opdata2_i),
    .done     (div_done),
    .busy     (div_busy_o),
    .run      (div_run),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hilo <= HILO_RST_VAL;
    end else if (flush_i) begin
      hilo <= hilo;
    end else if (div_done) begin
      hilo <= {div_rem, div_quo};
    end else if (fire && !div_busy_o) begin
      unique case (aluop_i)
        OP_MTHI:  hilo[63:32] <= opdata1_i;
        OP_MTLO:  hilo[31:0]  <= opdata1_i;
        OP_MULT:  hilo        <= prod_s;
        OP_MULTU: hilo        <= prod_u;
        OP_DIV, OP_DIVU: if (div_zero) hilo <= {opdata1_i, 32'hFFFF_FFFF};
        default:  hilo <= hilo;
      endcase
    end
  end

  assign hilo_rdata_o = hilo;

endmodule
